rom_seq_reader: RTL and testbench

ROM_SEQ_READER -- requirements
Module: rom_seq_reader

---
 rtl/rom_seq_reader.sv | 105 ++++++++++
 tb/tb_rom_seq_reader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rom_seq_reader.sv
// Burst reader over a fixed address-pattern ROM, one beat per cycle.
// Ports: clk, rst_n, req_* (burst request), rsp_* (beat stream), busy.
// Optional: ROM_SEQ_READER_PARITY_EN adds rsp_parity (XOR of rsp_data).
module rom_seq_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy
`ifdef ROM_SEQ_READER_PARITY_EN
  ,
  output logic              rsp_parity
`endif
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_nxt;

  // Word a is a repeated from the LSB, so bit b is a[b mod ADDR_W].
  function automatic logic [DATA_W-1:0] word(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] w;
    w = '0;
    for (int b = 0; b < DATA_W; b++) begin
      w[b] = a[b % ADDR_W];
    end
    return w;
  endfunction

  assign addr_nxt = addr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_data   <= '0;
      addr       <= '0;
      cnt        <= '0;
`ifdef ROM_SEQ_READER_PARITY_EN
      rsp_parity <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            state     <= BURST;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            addr      <= req_addr;
            cnt       <= req_len;
            rsp_valid <= 1'b1;
            rsp_last  <= (req_len == '0);
            rsp_data  <= word(req_addr);
`ifdef ROM_SEQ_READER_PARITY_EN
            rsp_parity <= ^word(req_addr);
`endif
          end
        end
        BURST: begin
          if (rsp_valid && rsp_ready) begin
            if (rsp_last) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
            end else begin
              // cnt counts beats still to come after the current one.
              addr     <= addr_nxt;
              cnt      <= cnt - 1'b1;
              rsp_last <= (cnt == ADDR_W'(1));
              rsp_data <= word(addr_nxt);
`ifdef ROM_SEQ_READER_PARITY_EN
              rsp_parity <= ^word(addr_nxt);
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader (default parameters).
// Checks reset, single/burst/wrap/stall/abort/full-depth reads.
module tb_rom_seq_reader;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [3:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        busy;
`ifdef ROM_SEQ_READER_PARITY_EN
  logic        rsp_parity;
`endif

  int errors = 0;
  int checks = 0;

  rom_seq_reader #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy)
`ifdef ROM_SEQ_READER_PARITY_EN
    ,
    .rsp_parity(rsp_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(string tag, logic [15:0] d, logic l);
    chk({tag, "_v"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_d"}, 32'(rsp_data), 32'(d));
    chk({tag, "_l"}, 32'(rsp_last), 32'(l));
    chk({tag, "_bz"}, 32'(busy), 32'd1);
`ifdef ROM_SEQ_READER_PARITY_EN
    chk({tag, "_p"}, 32'(rsp_parity), 32'(^d));
`endif
  endtask

  task automatic idle_chk(string tag);
    chk({tag, "_iv"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ir"}, 32'(req_ready), 32'd1);
    chk({tag, "_ib"}, 32'(busy), 32'd0);
  endtask

  task automatic issue(logic [3:0] a, logic [3:0] l);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_burst(string tag, logic [3:0] a, logic [3:0] l);
    logic [3:0] ea;
    rsp_ready = 1'b1;
    issue(a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 4'(i);
      beat($sformatf("%s%0d", tag, i), {4{ea}}, i == int'(l));
      step();
    end
    idle_chk(tag);
  endtask

  logic [15:0] v031[4];

  initial begin
    v031 = '{16'hEEEE, 16'hFFFF, 16'h0000, 16'h1111};
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_v", 32'(rsp_valid), 32'd0);
    chk("rst_d", 32'(rsp_data), 32'd0);
    chk("rst_b", 32'(busy), 32'd0);
    chk("rst_r", 32'(req_ready), 32'd0);
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    idle_chk("post_rst");
    chk("post_rst_d", 32'(rsp_data), 32'd0);

    run_burst("b030_", 4'd3, 4'd0);

    rsp_ready = 1'b1;
    issue(4'd14, 4'd3);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("b031_%0d", i), v031[i], i == 3);
      step();
    end
    idle_chk("b031");

    rsp_ready = 1'b1;
    issue(4'd5, 4'd2);
    beat("b032_0", 16'h5555, 1'b0);
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'd0;
    req_len   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("b032_hold%0d", i), 16'h6666, 1'b0);
      chk("b032_rr", 32'(req_ready), 32'd0);
      step();
    end
    beat("b032_hold3", 16'h6666, 1'b0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    beat("b032_2", 16'h7777, 1'b1);
    step();
    idle_chk("b032");
    step();
    chk("b032_noq", 32'(rsp_valid), 32'd0);

    rsp_ready = 1'b1;
    issue(4'd0, 4'd15);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("b033_%0d", i), {4{4'(i)}}, 1'b0);
      step();
    end
    #3 rst_n = 1'b0;
    #1;
    chk("b033_rv", 32'(rsp_valid), 32'd0);
    chk("b033_rd", 32'(rsp_data), 32'd0);
    chk("b033_rl", 32'(rsp_last), 32'd0);
    chk("b033_rb", 32'(busy), 32'd0);
    chk("b033_rr", 32'(req_ready), 32'd0);
    step();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("b033_quiet%0d", i), 32'(rsp_valid), 32'd0);
    end
    run_burst("b033n_", 4'd9, 4'd0);

    run_burst("b023_", 4'd10, 4'd15);
    run_burst("b_wrap_", 4'd15, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
